alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arithmetic/shift ops and an
// iterative shift-add multiplier.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready  request handshake; a, b, sel are sampled on accept
//   a, b                 WIDTH-bit operands
//   sel                  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 MUL,
//                        110 SLL, 111 SRL
//   out_valid/out_ready  result handshake; c and flags held until consumed
//   c                    registered WIDTH-bit result
//   flag_z/n/c/v         zero, negative, carry/borrow/shift-out, signed overflow
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  // Single-cycle ops. Returns {carry, overflow, result}.
  function automatic logic [WIDTH+1:0] alu_single(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0]   r;
    logic               fc;
    logic               fv;
    logic [WIDTH:0]     wide;
    logic signed [WIDTH:0] ssum;
    logic               big;
    r    = '0;
    fc   = 1'b0;
    fv   = 1'b0;
    wide = '0;
    ssum = '0;
    big  = (32'(y) >= 32'(WIDTH));
    case (op)
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_ADD: begin
        wide = {1'b0, x} + {1'b0, y};
        r    = wide[WIDTH-1:0];
        fc   = wide[WIDTH];
        // One guard bit: overflow iff the top two bits of the signed sum differ.
        ssum = $signed({x[WIDTH-1], x}) + $signed({y[WIDTH-1], y});
        fv   = ssum[WIDTH] ^ ssum[WIDTH-1];
      end
      OP_SUB: begin
        wide = {1'b0, x} - {1'b0, y};
        r    = wide[WIDTH-1:0];
        fc   = wide[WIDTH];
        ssum = $signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y});
        fv   = ssum[WIDTH] ^ ssum[WIDTH-1];
      end
      // An extra bit beside the operand catches the last bit shifted out;
      // a zero shift leaves it 0 naturally.
      OP_SLL: begin
        if (!big) begin
          wide = {1'b0, x} << y;
          r    = wide[WIDTH-1:0];
          fc   = wide[WIDTH];
        end
      end
      OP_SRL: begin
        if (!big) begin
          wide = {x, 1'b0} >> y;
          r    = wide[WIDTH:1];
          fc   = wide[0];
        end
      end
      default: r = '0;
    endcase
    return {fc, fv, r};
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic             accept, mul_start, mul_step, ld_single, ld_mul;
  logic [WIDTH-1:0] mul_x, mul_y, mul_acc;
  logic [WIDTH+1:0] single;
  logic [WIDTH-1:0] res_val;
  logic             res_c, res_v;

  assign single = alu_single(sel, a, b);

  always_comb begin
    res_val = single[WIDTH-1:0];
    res_c   = single[WIDTH+1];
    res_v   = single[WIDTH];
    if (ld_mul) begin
      res_val = mul_acc;
      res_c   = 1'b0;
      res_v   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    ld_single = 1'b0;
    ld_mul    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        if (accept) begin
          if (sel == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            ld_single = 1'b1;
          end
        end
      end
      MUL: begin
        // WIDTH edges consume multiplier bits; the next edge publishes.
        if (cnt == CW'(WIDTH)) begin
          ld_mul  = 1'b1;
          state_d = IDLE;
        end else begin
          mul_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (mul_start)  cnt <= '0;
    else if (mul_step)   cnt <= cnt + CW'(1);
    else if (ld_mul)     cnt <= '0;
  end

  // Multiplier datapath: shift-add, one bit of mul_y per cycle.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      mul_x   <= a;
      mul_y   <= b;
      mul_acc <= '0;
    end else if (mul_step) begin
      mul_acc <= mul_acc + (mul_y[0] ? mul_x : '0);
      mul_x   <= mul_x << 1;
      mul_y   <= mul_y >> 1;
    end
  end

  // Result stage: load on completion, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (ld_single || ld_mul) begin
      out_valid <= 1'b1;
      c         <= res_val;
      flag_z    <= (res_val == '0);
      flag_n    <= res_val[WIDTH-1];
      flag_c    <= res_c;
      flag_v    <= res_v;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
